// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the dual-port SRAM arbiter: FSM encoding and the
// pended request bundle.
package sram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_PEND_I = 2'd1,
      ARB_DRAIN  = 2'd2
   } arb_state_e;

   // {vld, wen, addr, wdata}: the valid bit marks a live pended request
   localparam int SRAM_REQ_WD = 69;

   typedef struct packed {
      logic        vld;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } sram_req_t;

   // A request with no byte enables is a read and returns data next cycle
   function automatic logic is_read(input logic [3:0] wen);
      return (wen == 4'b0000);
   endfunction

endpackage

// File: rtl/sram_port_arbiter_req_hold.sv
// Holding register for the instruction request deferred by a conflict.
// Load has priority over clear; both are synchronous, reset is async.
module sram_req_hold
   import sram_port_arbiter_pkg::*;
(
   input  logic      clk,
   input  logic      resetn,
   input  logic      load_i,
   input  logic      clear_i,
   input  sram_req_t req_i,
   output sram_req_t req_o
);

   sram_req_t req_q;

   // Capture the request on load, drop it once it has been issued
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_q <= '0;
      end else if (load_i) begin
         req_q <= req_i;
      end else if (clear_i) begin
         req_q <= '0;
      end
   end

   assign req_o = req_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbiter that serves the core's inst/data SRAM ports from one single-port
// synchronous RAM (1-cycle read latency). Same-cycle conflicts issue the
// data access first, defer the inst access by one cycle and stall the core.
// Optional build macro SRAM_ARB_PERF_EN adds a saturating conflict counter.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 16
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_sram_en,
   input  logic [DATA_W/8-1:0] inst_sram_wen,
   input  logic [ADDR_W-1:0]   inst_sram_addr,
   input  logic [DATA_W-1:0]   inst_sram_wdata,
   output logic [DATA_W-1:0]   inst_sram_rdata,
   input  logic                data_sram_en,
   input  logic [DATA_W/8-1:0] data_sram_wen,
   input  logic [ADDR_W-1:0]   data_sram_addr,
   input  logic [DATA_W-1:0]   data_sram_wdata,
   output logic [DATA_W-1:0]   data_sram_rdata,
   output logic                stallreq_from_outside,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_wen,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef SRAM_ARB_PERF_EN
   ,
   output logic [31:0]         conflict_cnt
`endif
);

   arb_state_e        state_q, state_d;
   sram_req_t         pend_in, pend_q;
   logic              conflict;
   logic              sel_i_q, sel_i_d, sel_d_q, sel_d_d;
   logic [DATA_W-1:0] i_hold_q, i_hold_d, d_hold_q, d_hold_d;
   logic              unused_addr_bits;

   // Both ports asking while the memory is free to take new requests
   assign conflict = (state_q != ARB_PEND_I) && inst_sram_en && data_sram_en;

   assign pend_in = '{vld: 1'b1, wen: inst_sram_wen, addr: inst_sram_addr,
                      wdata: inst_sram_wdata};

   sram_req_hold u_pend (
      .clk     (clk),
      .resetn  (resetn),
      .load_i  (conflict),
      .clear_i (state_q == ARB_PEND_I),
      .req_i   (pend_in),
      .req_o   (pend_q)
   );

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: PEND_I always drains; IDLE and DRAIN accept new work
   always_comb begin
      state_d = ARB_IDLE;
      case (state_q)
         ARB_PEND_I: state_d = ARB_DRAIN;
         default:    state_d = conflict ? ARB_PEND_I : ARB_IDLE;
      endcase
   end

   // FSM outputs: memory request mux and stall; reset forces both quiet
   always_comb begin
      mem_en                = 1'b0;
      mem_wen               = '0;
      mem_addr              = '0;
      mem_wdata             = '0;
      stallreq_from_outside = 1'b0;
      case (state_q)
         ARB_PEND_I: begin
            mem_en                = pend_q.vld;
            mem_wen               = pend_q.wen;
            mem_addr              = pend_q.addr[MEM_AW+1:2];
            mem_wdata             = pend_q.wdata;
            stallreq_from_outside = 1'b1;
         end
         default: begin
            if (data_sram_en) begin
               mem_en                = 1'b1;
               mem_wen               = data_sram_wen;
               mem_addr              = data_sram_addr[MEM_AW+1:2];
               mem_wdata             = data_sram_wdata;
               stallreq_from_outside = inst_sram_en;
            end else if (inst_sram_en) begin
               mem_en    = 1'b1;
               mem_wen   = inst_sram_wen;
               mem_addr  = inst_sram_addr[MEM_AW+1:2];
               mem_wdata = inst_sram_wdata;
            end
         end
      endcase
      if (!resetn) begin
         mem_en                = 1'b0;
         stallreq_from_outside = 1'b0;
      end
   end

   // Which port owns next cycle's mem_rdata (reads only; writes return nothing)
   always_comb begin
      sel_i_d = 1'b0;
      sel_d_d = 1'b0;
      if (state_q == ARB_PEND_I) begin
         sel_i_d = pend_q.vld && is_read(pend_q.wen);
      end else begin
         sel_i_d = inst_sram_en && !data_sram_en && is_read(inst_sram_wen);
         sel_d_d = data_sram_en && is_read(data_sram_wen);
      end
   end

   // Hold value including this cycle's capture, so rdata is live and stable
   assign i_hold_d        = sel_i_q ? mem_rdata : i_hold_q;
   assign d_hold_d        = sel_d_q ? mem_rdata : d_hold_q;
   assign inst_sram_rdata = i_hold_d;
   assign data_sram_rdata = d_hold_d;

   // Read-owner flags and per-port hold registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sel_i_q  <= 1'b0;
         sel_d_q  <= 1'b0;
         i_hold_q <= '0;
         d_hold_q <= '0;
      end else begin
         sel_i_q  <= sel_i_d;
         sel_d_q  <= sel_d_d;
         i_hold_q <= i_hold_d;
         d_hold_q <= d_hold_d;
      end
   end

   // Byte-offset and above-window address bits are deliberately ignored
   assign unused_addr_bits = ^{data_sram_addr[ADDR_W-1:MEM_AW+2], data_sram_addr[1:0],
                               pend_q.addr[31:MEM_AW+2], pend_q.addr[1:0]};

`ifdef SRAM_ARB_PERF_EN
   logic [31:0] conflict_cnt_q;

   // Count entries into PEND_I, saturating at all-ones
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         conflict_cnt_q <= '0;
      end else if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
         conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural 1-cycle-latency RAM plus a
// queue of expected rdata values pushed at request time, popped at return.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_en, data_sram_en;
   logic [3:0]  inst_sram_wen, data_sram_wen;
   logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
   logic        stallreq_from_outside;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
`ifdef SRAM_ARB_PERF_EN
   logic [31:0] conflict_cnt;
`endif

   typedef struct {
      bit          port;   // 0 = inst, 1 = data
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] obs;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mem [0:65535];

   always #5 clk = ~clk;

   sram_port_arbiter dut (
      .clk                   (clk),
      .resetn                (resetn),
      .inst_sram_en          (inst_sram_en),
      .inst_sram_wen         (inst_sram_wen),
      .inst_sram_addr        (inst_sram_addr),
      .inst_sram_wdata       (inst_sram_wdata),
      .inst_sram_rdata       (inst_sram_rdata),
      .data_sram_en          (data_sram_en),
      .data_sram_wen         (data_sram_wen),
      .data_sram_addr        (data_sram_addr),
      .data_sram_wdata       (data_sram_wdata),
      .data_sram_rdata       (data_sram_rdata),
      .stallreq_from_outside (stallreq_from_outside),
      .mem_en                (mem_en),
      .mem_wen               (mem_wen),
      .mem_addr              (mem_addr),
      .mem_wdata             (mem_wdata),
      .mem_rdata             (mem_rdata)
`ifdef SRAM_ARB_PERF_EN
      ,
      .conflict_cnt          (conflict_cnt)
`endif
   );

   // Single-port synchronous RAM, read-before-write, byte enables
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_wen[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic drive(input bit ie, input logic [31:0] ia,
                        input bit de, input logic [3:0] dw,
                        input logic [31:0] da, input logic [31:0] dd);
      inst_sram_en    = ie;
      inst_sram_wen   = 4'h0;
      inst_sram_addr  = ia;
      inst_sram_wdata = 32'h0;
      data_sram_en    = de;
      data_sram_wen   = dw;
      data_sram_addr  = da;
      data_sram_wdata = dd;
   endtask

   // Preload a word through the data port (one store cycle, then idle)
   task automatic store(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      drive(0, 0, 1, 4'hF, a, v);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      drive(1, 32'h10, 1, 4'h0, 32'h40, 0);
      #12;
      n_cmp++;
      if (stallreq_from_outside !== 1'b0) begin
         n_err++; $display("FAIL reset_stall: got %b want 0", stallreq_from_outside);
      end
      n_cmp++;
      if (mem_en !== 1'b0) begin
         n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en);
      end
      n_cmp++;
      if (inst_sram_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_inst_rdata: got %h want 0", inst_sram_rdata);
      end
      n_cmp++;
      if (data_sram_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_data_rdata: got %h want 0", data_sram_rdata);
      end
      drive(0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_single_fetch;
      store(32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      drive(1, 32'h10, 0, 4'h0, 0, 0);
      sb.push_back('{0, 32'hDEAD_BEEF});
      sb.push_back('{1, 32'h0});
      #1;
      n_cmp++;
      if (mem_en !== 1'b1 || mem_addr !== 16'd4 || mem_wen !== 4'h0) begin
         n_err++; $display("FAIL fetch_mem_req: got en=%b addr=%h wen=%h want 1/0004/0", mem_en, mem_addr, mem_wen);
      end
      n_cmp++;
      if (stallreq_from_outside !== 1'b0) begin
         n_err++; $display("FAIL fetch_stall_n: got %b want 0", stallreq_from_outside);
      end
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b0) begin
         n_err++; $display("FAIL fetch_stall_n1: got %b want 0", stallreq_from_outside);
      end
      repeat (2) begin
         e = sb.pop_front();
         obs = e.port ? data_sram_rdata : inst_sram_rdata;
         n_cmp++;
         if (obs !== e.val) begin
            n_err++; $display("FAIL fetch_rdata port%0d: got %h want %h", e.port, obs, e.val);
         end
      end
      @(negedge clk);
      sb.push_back('{0, 32'hDEAD_BEEF});
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (inst_sram_rdata !== e.val) begin
         n_err++; $display("FAIL fetch_hold: got %h want %h", inst_sram_rdata, e.val);
      end
   endtask

   task automatic test_conflict;
      store(32'h20, 32'h1111_1111);
      store(32'h40, 32'h2222_2222);
      @(negedge clk);
      drive(1, 32'h20, 1, 4'h0, 32'h40, 0);
      sb.push_back('{1, 32'h2222_2222});
      sb.push_back('{0, 32'h1111_1111});
      sb.push_back('{1, 32'h2222_2222});
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'd16) begin
         n_err++; $display("FAIL conf_n: got stall=%b en=%b addr=%h want 1/1/0010", stallreq_from_outside, mem_en, mem_addr);
      end
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'd8) begin
         n_err++; $display("FAIL conf_n1: got stall=%b en=%b addr=%h want 1/1/0008", stallreq_from_outside, mem_en, mem_addr);
      end
      e = sb.pop_front();
      n_cmp++;
      if (data_sram_rdata !== e.val) begin
         n_err++; $display("FAIL conf_n1_data: got %h want %h", data_sram_rdata, e.val);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b0 || mem_en !== 1'b0) begin
         n_err++; $display("FAIL conf_n2_quiet: got stall=%b en=%b want 0/0", stallreq_from_outside, mem_en);
      end
      repeat (2) begin
         e = sb.pop_front();
         obs = e.port ? data_sram_rdata : inst_sram_rdata;
         n_cmp++;
         if (obs !== e.val) begin
            n_err++; $display("FAIL conf_n2_rdata port%0d: got %h want %h", e.port, obs, e.val);
         end
      end
   endtask

   task automatic test_same_addr;
      @(negedge clk);
      drive(1, 32'h80, 1, 4'hF, 32'h80, 32'hCAFE_0001);
      sb.push_back('{0, 32'hCAFE_0001});
      sb.push_back('{1, 32'h2222_2222});
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1 || mem_wen !== 4'hF || mem_addr !== 16'd32) begin
         n_err++; $display("FAIL same_n: got stall=%b wen=%h addr=%h want 1/f/0020", stallreq_from_outside, mem_wen, mem_addr);
      end
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      #1;
      n_cmp++;
      if (mem_wen !== 4'h0 || mem_addr !== 16'd32) begin
         n_err++; $display("FAIL same_n1: got wen=%h addr=%h want 0/0020", mem_wen, mem_addr);
      end
      @(negedge clk);
      #1;
      repeat (2) begin
         e = sb.pop_front();
         obs = e.port ? data_sram_rdata : inst_sram_rdata;
         n_cmp++;
         if (obs !== e.val) begin
            n_err++; $display("FAIL same_rdata port%0d: got %h want %h", e.port, obs, e.val);
         end
      end
   endtask

   task automatic test_back_to_back;
      store(32'h100, 32'hA1A1_0001);
      store(32'h104, 32'hB1B1_0001);
      store(32'h108, 32'hA2A2_0002);
      store(32'h10C, 32'hB2B2_0002);
      @(negedge clk);
      drive(1, 32'h100, 1, 4'h0, 32'h104, 0);
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1) begin
         n_err++; $display("FAIL b2b_stall_n: got %b want 1", stallreq_from_outside);
      end
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1 || data_sram_rdata !== 32'hB1B1_0001) begin
         n_err++; $display("FAIL b2b_n1: got stall=%b data=%h want 1/b1b10001", stallreq_from_outside, data_sram_rdata);
      end
      @(negedge clk);
      drive(1, 32'h108, 1, 4'h0, 32'h10C, 0);
      sb.push_back('{0, 32'hA1A1_0001});
      sb.push_back('{1, 32'hB1B1_0001});
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1 || mem_addr !== 16'd67) begin
         n_err++; $display("FAIL b2b_drain: got stall=%b addr=%h want 1/0043", stallreq_from_outside, mem_addr);
      end
      repeat (2) begin
         e = sb.pop_front();
         obs = e.port ? data_sram_rdata : inst_sram_rdata;
         n_cmp++;
         if (obs !== e.val) begin
            n_err++; $display("FAIL b2b_drain_rdata port%0d: got %h want %h", e.port, obs, e.val);
         end
      end
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      sb.push_back('{1, 32'hB2B2_0002});
      sb.push_back('{0, 32'hA1A1_0001});
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1 || mem_addr !== 16'd66) begin
         n_err++; $display("FAIL b2b_pend2: got stall=%b addr=%h want 1/0042", stallreq_from_outside, mem_addr);
      end
      repeat (2) begin
         e = sb.pop_front();
         obs = e.port ? data_sram_rdata : inst_sram_rdata;
         n_cmp++;
         if (obs !== e.val) begin
            n_err++; $display("FAIL b2b_pend2_rdata port%0d: got %h want %h", e.port, obs, e.val);
         end
      end
      @(negedge clk);
      sb.push_back('{0, 32'hA2A2_0002});
      sb.push_back('{1, 32'hB2B2_0002});
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b0) begin
         n_err++; $display("FAIL b2b_end_stall: got %b want 0", stallreq_from_outside);
      end
      repeat (2) begin
         e = sb.pop_front();
         obs = e.port ? data_sram_rdata : inst_sram_rdata;
         n_cmp++;
         if (obs !== e.val) begin
            n_err++; $display("FAIL b2b_end_rdata port%0d: got %h want %h", e.port, obs, e.val);
         end
      end
   endtask

   task automatic test_addr_trunc;
      @(negedge clk);
      drive(0, 0, 1, 4'h0, 32'hFFFC_0010, 0);
      sb.push_back('{1, 32'hDEAD_BEEF});
      #1;
      n_cmp++;
      if (mem_addr !== 16'd4) begin
         n_err++; $display("FAIL trunc_addr: got %h want 0004", mem_addr);
      end
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (data_sram_rdata !== e.val) begin
         n_err++; $display("FAIL trunc_rdata: got %h want %h", data_sram_rdata, e.val);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      drive(1, 32'h20, 1, 4'h0, 32'h40, 0);
      @(negedge clk);
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b1) begin
         n_err++; $display("FAIL rmid_pend_stall: got %b want 1", stallreq_from_outside);
      end
      resetn = 1'b0;
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b0 || mem_en !== 1'b0) begin
         n_err++; $display("FAIL rmid_quiet: got stall=%b en=%b want 0/0", stallreq_from_outside, mem_en);
      end
      n_cmp++;
      if (inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0) begin
         n_err++; $display("FAIL rmid_holds: got inst=%h data=%h want 0/0", inst_sram_rdata, data_sram_rdata);
      end
      drive(0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      drive(1, 32'h10, 0, 4'h0, 0, 0);
      sb.push_back('{0, 32'hDEAD_BEEF});
      #1;
      n_cmp++;
      if (stallreq_from_outside !== 1'b0 || mem_addr !== 16'd4 || mem_en !== 1'b1) begin
         n_err++; $display("FAIL rmid_fetch_req: got stall=%b addr=%h en=%b want 0/0004/1", stallreq_from_outside, mem_addr, mem_en);
      end
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (inst_sram_rdata !== e.val) begin
         n_err++; $display("FAIL rmid_fetch_rdata: got %h want %h", inst_sram_rdata, e.val);
      end
   endtask

`ifdef SRAM_ARB_PERF_EN
   task automatic test_perf;
      n_cmp++;
      if (conflict_cnt !== 32'd0) begin
         n_err++; $display("FAIL perf_start: got %0d want 0", conflict_cnt);
      end
      repeat (3) begin
         @(negedge clk);
         drive(1, 32'h20, 1, 4'h0, 32'h40, 0);
         @(negedge clk);
         drive(0, 0, 0, 4'h0, 0, 0);
         @(negedge clk);
      end
      #1;
      n_cmp++;
      if (conflict_cnt !== 32'd3) begin
         n_err++; $display("FAIL perf_three: got %0d want 3", conflict_cnt);
      end
      @(negedge clk);
      force dut.conflict_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.conflict_cnt_q;
      @(negedge clk);
      drive(1, 32'h20, 1, 4'h0, 32'h40, 0);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      #1;
      n_cmp++;
      if (conflict_cnt !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL perf_sat: got %h want ffffffff", conflict_cnt);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_single_fetch;
      test_conflict;
      test_same_addr;
      test_back_to_back;
      test_addr_trunc;
      test_reset_mid;
`ifdef SRAM_ARB_PERF_EN
      test_perf;
`endif
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
